clk_div_gen: RTL and testbench

Parametrised multi-channel clock-divider / clock-enable generator. It replaces the single fixed divide-by-2 dividers with CHANNELS independent counters. Each channel has a runtime-programmable divide ratio, a per-channel idle level and a per-channel enable. Each channel drives a divided clock-level output and a one-cycle tick. Ratio changes take effect only at a period boundary, so slow-domain logic never sees a runt pulse.

---
 rtl/clk_div_gen.sv | 144 ++++++++++++++
 tb/tb_clk_div_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel clock-divider / clock-enable generator. Each of CHANNELS
// independent channels divides the system clock by a runtime-programmable
// ratio D (2 .. 2^CNT_W-1). Each channel produces a registered divided level
// and a one-cycle tick on every transition away from its idle level.
// A new ratio is written into a shadow register. It is applied only at a
// period boundary, or immediately if the channel is disabled, so the
// divided clock never produces a runt pulse.
//
// Parameters
//   CHANNELS   number of independent divider channels (1..16)
//   CNT_W      width of the divide ratio and the per-channel counter
//   CH_W       width of cfg_ch (2^CH_W >= CHANNELS)
//   RESET_DIV  ratio loaded into every channel at reset (values < 2 become 2)
//   INIT_LEVEL per-channel idle / first-half level of clk_o
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous active-high reset
//   en       in   per-channel run enable; 0 freezes the channel
//   cfg_we   in   one-cycle write strobe for a new divide ratio
//   cfg_ch   in   target channel of the write (out-of-range writes ignored)
//   cfg_div  in   new divide ratio (0 and 1 are treated as 2)
//   clk_o    out  divided clock level per channel
//   tick_o   out  one-cycle pulse when clk_o moves to ~INIT_LEVEL
//   pend_o   out  channel holds a written ratio that is not yet applied
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int                  CHANNELS   = 2,
    parameter int                  CNT_W      = 8,
    parameter int                  CH_W       = 1,
    parameter int                  RESET_DIV  = 2,
    parameter logic [CHANNELS-1:0] INIT_LEVEL = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] pend_o
);

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV = (RESET_DIV < 2) ? MIN_DIV : CNT_W'(RESET_DIV);

    // Ratios below 2 cannot form a two-phase period, so they run as 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] div_q,  div_d;   // active ratio
        logic [CNT_W-1:0] sdiv_q, sdiv_d;  // shadow ratio awaiting a boundary
        logic [CNT_W-1:0] cnt_q,  cnt_d;   // position within the current period
        logic             pend_q, pend_d;
        logic             lvl_q,  lvl_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] eff_div;
        logic [CNT_W-1:0] half;
        logic             wr_hit;

        assign eff_div = clamp_div(div_q);
        assign half    = eff_div >> 1;
        // Widening both sides makes any cfg_ch at or above CHANNELS match no channel.
        assign wr_hit  = cfg_we && (32'(cfg_ch) == 32'(i));

        always_comb begin
            // NOTE: every next-state signal takes its hold value first, so each
            // path through the block assigns it and no latch is inferred.
            div_d  = div_q;
            sdiv_d = sdiv_q;
            pend_d = pend_q;
            cnt_d  = cnt_q;
            lvl_d  = lvl_q;
            tick_d = 1'b0;

            if (en[i]) begin
                if (cnt_q == eff_div - ONE) begin
                    // Period boundary: the only point where a running channel
                    // may switch ratio without truncating a phase.
                    cnt_d = '0;
                    lvl_d = INIT_LEVEL[i];
                    if (pend_q) begin
                        div_d  = sdiv_q;
                        pend_d = 1'b0;
                    end
                end else if (cnt_q == half - ONE) begin
                    cnt_d  = cnt_q + ONE;
                    lvl_d  = ~INIT_LEVEL[i];
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (pend_q) begin
                // A stopped channel has no phase to protect. Apply the new ratio
                // at once and restart from a clean boundary.
                div_d  = sdiv_q;
                pend_d = 1'b0;
                cnt_d  = '0;
                lvl_d  = INIT_LEVEL[i];
            end

            // The write comes last so it wins over a same-cycle boundary load.
            // The load above has already consumed the old shadow value, so the
            // new ratio waits for the next boundary.
            if (wr_hit) begin
                sdiv_d = clamp_div(cfg_div);
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so that every
            // register samples values from before the edge. This keeps the
            // outcome independent of the order of the processes.
            if (rst) begin
                div_q  <= RST_DIV;
                sdiv_q <= RST_DIV;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                lvl_q  <= INIT_LEVEL[i];
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                sdiv_q <= sdiv_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                lvl_q  <= lvl_d;
                tick_q <= tick_d;
            end
        end

        assign clk_o[i]  = lvl_q;
        assign tick_o[i] = tick_q;
        assign pend_o[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
//
// Directed bench for clk_div_gen using two channels with INIT_LEVEL = 2'b10
// (channel 0 idles low, channel 1 idles high) and a 2-bit cfg_ch so that
// out-of-range channel numbers can be driven.
//
// Each row drives the inputs on the falling edge. The same row pushes the
// hand-computed outputs expected after the next rising edge into a queue.
// A separate monitor pops one entry on every rising edge (+1) and compares
// clk_o, tick_o and pend_o against it.
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [1:0] clk_o;
    logic [1:0] tick_o;
    logic [1:0] pend_o;

    clk_div_gen #(
        .CHANNELS  (2),
        .CNT_W     (8),
        .CH_W      (2),
        .RESET_DIV (2),
        .INIT_LEVEL(2'b10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_div(cfg_div),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .pend_o (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] c;
        logic [1:0] t;
        logic [1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   row_n = 0;

    task automatic check(input string name, input int idx,
                         input logic [1:0] got, input logic [1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL row %0d %s: got %b expected %b", idx, name, got, want);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("clk_o",  e.idx, clk_o,  e.c);
            check("tick_o", e.idx, tick_o, e.t);
            check("pend_o", e.idx, pend_o, e.p);
        end
    end

    // One stimulus row: drive the inputs for the next edge and push the expected result.
    task automatic step(input logic r, input logic [1:0] e_en, input logic w,
                        input logic [1:0] ch, input logic [7:0] d,
                        input logic [1:0] xc, input logic [1:0] xt, input logic [1:0] xp);
        exp_t x;
        @(negedge clk);
        rst     = r;
        en      = e_en;
        cfg_we  = w;
        cfg_ch  = ch;
        cfg_div = d;
        row_n++;
        x.idx = row_n;
        x.c   = xc;
        x.t   = xt;
        x.p   = xp;
        exp_q.push_back(x);
    endtask

    // Shorthand for a free-running cycle with both channels enabled and no write.
    task automatic run(input logic [1:0] xc, input logic [1:0] xt, input logic [1:0] xp);
        step(1'b0, 2'b11, 1'b0, 2'd0, 8'd0, xc, xt, xp);
    endtask

    initial begin
        rst = 1'b1; en = 2'b11; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;

        // Reset values. A write during reset is ignored.
        step(1, 2'b11, 0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00);
        step(1, 2'b11, 1, 2'd0, 8'd5, 2'b10, 2'b00, 2'b00);

        // Legacy divide-by-2 on both channels, opposite idle levels.
        run(2'b01, 2'b11, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);

        // D=5 to ch0 landing as cnt returns to 0: pending for two cycles, then low 2 / high 3.
        step(0, 2'b11, 1, 2'd0, 8'd5, 2'b10, 2'b00, 2'b01);
        run(2'b01, 2'b11, 2'b01);
        run(2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b11, 2'b01, 2'b00);
        run(2'b01, 2'b10, 2'b00);
        run(2'b11, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);

        // ch1: D=0 then D=1, both clamp to 2; ch1 must keep toggling every cycle.
        step(0, 2'b11, 1, 2'd1, 8'd0, 2'b11, 2'b00, 2'b10);
        step(0, 2'b11, 1, 2'd1, 8'd1, 2'b01, 2'b10, 2'b10);
        run(2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b11, 2'b01, 2'b00);

        // Writes to channels 3 and 2 do not exist and change nothing.
        step(0, 2'b11, 1, 2'd3, 8'd9, 2'b01, 2'b10, 2'b00);
        step(0, 2'b11, 1, 2'd2, 8'd9, 2'b11, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);

        // Disable ch0 in its high phase, write D=4 while it is stopped, then re-enable.
        step(0, 2'b10, 0, 2'd0, 8'd0, 2'b11, 2'b00, 2'b00);
        step(0, 2'b10, 0, 2'd0, 8'd0, 2'b01, 2'b10, 2'b00);
        step(0, 2'b10, 1, 2'd0, 8'd4, 2'b11, 2'b00, 2'b01);
        step(0, 2'b10, 0, 2'd0, 8'd0, 2'b00, 2'b10, 2'b00);
        step(0, 2'b10, 0, 2'd0, 8'd0, 2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b11, 2'b01, 2'b00);
        run(2'b01, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b11, 2'b01, 2'b00);

        // Pending D=3, then D=6 written on the boundary: D=3 for one period, then D=6.
        step(0, 2'b11, 1, 2'd0, 8'd3, 2'b01, 2'b10, 2'b01);
        step(0, 2'b11, 1, 2'd0, 8'd6, 2'b10, 2'b00, 2'b01);
        run(2'b01, 2'b11, 2'b01);
        run(2'b11, 2'b00, 2'b01);
        run(2'b00, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b11, 2'b01, 2'b00);
        run(2'b01, 2'b10, 2'b00);
        run(2'b11, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);

        // Back-to-back writes 7 then 9: only 9 is applied (low 4 / high 5).
        step(0, 2'b11, 1, 2'd0, 8'd7, 2'b10, 2'b00, 2'b01);
        step(0, 2'b11, 1, 2'd0, 8'd9, 2'b00, 2'b10, 2'b01);
        run(2'b11, 2'b01, 2'b01);
        run(2'b01, 2'b10, 2'b01);
        run(2'b11, 2'b00, 2'b01);
        run(2'b00, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b00, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);
        run(2'b11, 2'b00, 2'b00);
        run(2'b01, 2'b10, 2'b00);
        run(2'b11, 2'b00, 2'b00);
        run(2'b01, 2'b10, 2'b00);
        run(2'b10, 2'b00, 2'b00);

        // Reset mid-period with both channels pending: everything returns to reset
        // state and the channels resume at the reset ratio of 2.
        step(0, 2'b11, 1, 2'd0, 8'd5, 2'b00, 2'b10, 2'b01);
        step(0, 2'b11, 1, 2'd1, 8'd7, 2'b10, 2'b00, 2'b11);
        step(1, 2'b11, 1, 2'd0, 8'd3, 2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);
        run(2'b10, 2'b00, 2'b00);
        run(2'b01, 2'b11, 2'b00);
        run(2'b10, 2'b00, 2'b00);

        // Let the monitor drain the last entry; a bounded wait, then confirm it did.
        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
